// File: rtl/instr_mem_loader_pkg.sv
// Shared types and byte counts for the boot-time instruction memory loader.
// LOADER_CHECKSUM_EN adds the CSUM state to the state enum.
package loader_pkg;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CSUM  = 3'd6
`endif
    } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host byte stream plus instruction memory write port of the loader.
interface instr_mem_loader_if;
    // A byte moves on every rising edge where byte_valid && byte_ready; the host
    // holds byte_data stable while byte_valid is high and byte_ready is low.
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// Little-endian 4-byte assembler shared by the header, payload and checksum phases.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [31:0] word_unused_hi,
    output logic        word_full
);
    logic [1:0]  cnt;
    logic [31:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 2'd0;
            sr  <= 32'd0;
        end else if (clear) begin
            cnt <= 2'd0;
            sr  <= 32'd0;
        end else if (accept) begin
            cnt <= cnt + 2'd1;
            sr  <= {byte_in, sr[31:8]};
        end
    end

    // Presents the completed word in the same cycle the last byte is accepted.
    assign word           = accept ? {byte_in, sr[31:8]} : sr;
    assign word_unused_hi = sr;
    assign word_full      = accept && (cnt == 2'(WORD_BYTES - 1));
endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: byte stream -> instruction memory words, holds the core until done.
// Optional LOADER_CHECKSUM_EN appends an XOR checksum word after the payload.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_mem_loader_if.slave   bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [31:0]         words_loaded,
    output loader_state_t       state_dbg
);
    loader_state_t state;
    logic          ready_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   n_words;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   csum_q;
`endif
    logic          accept;
    logic          asm_clear;
    logic          word_full;
    logic [31:0]   asm_word;
    logic [31:0]   asm_raw;

    assign accept    = bus.byte_valid && ready_q;
    assign asm_clear = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

    byte_assembler u_asm (
        .clk            (clk),
        .rst            (rst),
        .clear          (asm_clear),
        .accept         (accept),
        .byte_in        (bus.byte_data),
        .word           (asm_word),
        .word_unused_hi (asm_raw),
        .word_full      (word_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            n_words      <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 32'd0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state        <= ST_HDR;
                        ready_q      <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q       <= 32'd0;
`endif
                    end
                end
                ST_HDR: begin
                    if (word_full) begin
                        n_words <= asm_word;
                        if (asm_word > 32'(MAX_WORDS)) begin
                            state   <= ST_ERR;
                            ready_q <= 1'b0;
                            error   <= 1'b1;
                        end else if (asm_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= ST_CSUM;
`else
                            state    <= ST_DONE;
                            ready_q  <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_full) begin
                        state   <= ST_WRITE;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        addr_q  <= BASE_ADDR + {words_loaded[29:0], 2'b00};
                        wdata_q <= asm_word;
                    end
                end
                ST_WRITE: begin
                    words_loaded <= words_loaded + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_q       <= csum_q ^ wdata_q;
`endif
                    if ((words_loaded + 32'd1) == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                        state    <= ST_CSUM;
                        ready_q  <= 1'b1;
`else
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        state   <= ST_DATA;
                        ready_q <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (word_full) begin
                        ready_q <= 1'b0;
                        if (asm_word == csum_q) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign state_dbg      = state;

    // The raw shift register is only exposed for debug taps.
    logic unused_raw;
    assign unused_raw = ^asm_raw;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a stream-level model.
module tb_instr_mem_loader;
    import loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [31:0]   words_loaded;
    loader_state_t state_dbg;

    instr_mem_loader_if bus();

    instr_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus.slave),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0]  stream_q[$];
    logic [31:0] words_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int          overlap = 0;
    bit          exp_done;
    bit          exp_err;
    logic [31:0] exp_words;

    always @(negedge clk) begin
        if (rst && bus.mem_we) begin
            obs_q.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.byte_ready) overlap++;
        end
    end

    // Reference model: stream bytes and the writes/outcome a load must produce.
    task automatic model_load(input logic [31:0] n, input bit bad_csum);
        logic [31:0] x;
        logic [31:0] w;
        x = 32'd0;
        stream_q.delete();
        exp_q.delete();
        for (int b = 0; b < 4; b++) stream_q.push_back(8'(n >> (8 * b)));
        if (n > MAXW) begin
            exp_done  = 1'b0;
            exp_err   = 1'b1;
            exp_words = 32'd0;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            w = words_q[i];
            x = x ^ w;
            for (int b = 0; b < 4; b++) stream_q.push_back(8'(w >> (8 * b)));
            exp_q.push_back({BASE + 32'(4 * i), w});
        end
        exp_words = n;
        if (CSUM_ON) begin
            w = x ^ (bad_csum ? 32'h7 : 32'h0);
            for (int b = 0; b < 4; b++) stream_q.push_back(8'(w >> (8 * b)));
            exp_done = !bad_csum;
            exp_err  = bad_csum;
        end else begin
            exp_done = 1'b1;
            exp_err  = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start;
        @(negedge clk);
        start = 1'b1;
        obs_q.delete();
        overlap = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
    task automatic drive_stream(input int mode, output bit all_sent);
        int   idx;
        int   guard;
        logic v;
        logic rdy;
        idx   = 0;
        guard = 0;
        while (idx < stream_q.size() && guard < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.byte_valid = v;
            bus.byte_data  = v ? stream_q[idx] : 8'($urandom());
            rdy = bus.byte_ready;
            @(posedge clk);
            if (v && rdy) idx++;
            @(negedge clk);
            guard++;
        end
        bus.byte_valid = 1'b0;
        all_sent = (idx == stream_q.size());
    endtask

    task automatic wait_end(output bit timed_out);
        int c;
        c = 0;
        while (!(done || error) && c < 200) begin
            @(negedge clk);
            c++;
        end
        timed_out = !(done || error);
    endtask

    task automatic run_load(input int mode, output bit bad_run, output int cycles);
        int s;
        bit sent;
        bit to;
        do_start();
        s = cyc;
        drive_stream(mode, sent);
        wait_end(to);
        cycles  = cyc - s;
        bad_run = to || !sent;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cpu_hold !== 1'b1)       begin failures++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        checks++; if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL reset_byte_ready: got %b want 0", bus.byte_ready); end
        checks++; if (bus.mem_we !== 1'b0)     begin failures++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        checks++; if (done !== 1'b0)           begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (error !== 1'b0)          begin failures++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (bus.mem_addr !== 32'd0)  begin failures++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        checks++; if (words_loaded !== 32'd0)  begin failures++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
    endtask

    task automatic test_basic;
        bit bad;
        int cycles;
        words_q = '{32'h00500093, 32'h00A00113};
        model_load(32'd2, 1'b0);
        run_load(0, bad, cycles);
        checks++; if (bad) begin failures++; $display("FAIL basic_run: stream not consumed or timed out"); end
        checks++; if (cycles != 14 + (CSUM_ON ? 4 : 0)) begin failures++; $display("FAIL basic_latency: got %0d want %0d", cycles, 14 + (CSUM_ON ? 4 : 0)); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_write_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (words_loaded !== exp_words) begin failures++; $display("FAIL basic_words: got %0d want %0d", words_loaded, exp_words); end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL basic_status: got done=%b hold=%b err=%b want 1 0 0", done, cpu_hold, error); end
    endtask

    task automatic test_backpressure;
        bit bad;
        int cycles;
        words_q = '{32'hDEADBEEF};
        model_load(32'd1, 1'b0);
        run_load(1, bad, cycles);
        checks++; if (bad) begin failures++; $display("FAIL bp_run: stream not consumed or timed out"); end
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL bp_write_count: got %0d want 1", obs_q.size()); end
        checks++; if (obs_q.size() > 0 && obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL bp_write: got %h want %h", obs_q[0], exp_q[0]); end
        checks++; if (overlap != 0) begin failures++; $display("FAIL bp_ready_in_write: got %0d cycles want 0", overlap); end
        checks++; if (done !== exp_done || words_loaded !== 32'd1) begin failures++; $display("FAIL bp_status: got done=%b words=%0d want %b 1", done, words_loaded, exp_done); end
    endtask

    task automatic test_oversize;
        bit bad;
        int cycles;
        words_q.delete();
        model_load(32'd1025, 1'b0);
        run_load(0, bad, cycles);
        checks++; if (bad) begin failures++; $display("FAIL over_run: header not consumed or timed out"); end
        checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL over_status: got err=%b hold=%b done=%b want 1 1 0", error, cpu_hold, done); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL over_writes: got %0d want 0", obs_q.size()); end
        checks++; if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL over_ready: got %b want 0", bus.byte_ready); end
    endtask

    task automatic test_empty_reload;
        bit bad;
        int cycles;
        bit sent;
        bit to;
        words_q.delete();
        model_load(32'd0, 1'b0);
        run_load(0, bad, cycles);
        checks++; if (bad) begin failures++; $display("FAIL empty_run: stream not consumed or timed out"); end
        checks++; if (done !== exp_done || cpu_hold !== !exp_done || obs_q.size() != 0 || words_loaded !== 32'd0) begin
            failures++; $display("FAIL empty_status: got done=%b hold=%b writes=%0d words=%0d want %b %b 0 0", done, cpu_hold, obs_q.size(), words_loaded, exp_done, !exp_done);
        end
        words_q = '{$urandom()};
        model_load(32'd1, 1'b0);
        do_start();
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL reload_hold: got hold=%b done=%b want 1 0", cpu_hold, done); end
        drive_stream(2, sent);
        wait_end(to);
        checks++; if (!sent || to) begin failures++; $display("FAIL reload_run: stream not consumed or timed out"); end
        checks++; if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin failures++; $display("FAIL reload_write: got %0d writes first %h want 1 write %h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 64'd0, exp_q[0]); end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL reload_status: got done=%b hold=%b want 1 0", done, cpu_hold); end
    endtask

    task automatic test_reset_midword;
        bit sent;
        bit bad;
        int cycles;
        words_q = '{$urandom(), $urandom(), $urandom()};
        model_load(32'd3, 1'b0);
        // header, one full word, then 2 bytes of the second word
        while (stream_q.size() > 10) void'(stream_q.pop_back());
        do_start();
        drive_stream(0, sent);
        #2 rst = 1'b0;
        #1;
        checks++; if (cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0 || bus.mem_we !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl: got hold=%b rdy=%b we=%b done=%b err=%b want 1 0 0 0 0", cpu_hold, bus.byte_ready, bus.mem_we, done, error);
        end
        checks++; if (words_loaded !== 32'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
            failures++; $display("FAIL midrst_data: got words=%0d addr=%h wdata=%h want 0 0 0", words_loaded, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        words_q = '{$urandom(), $urandom()};
        model_load(32'd2, 1'b0);
        run_load(2, bad, cycles);
        checks++; if (bad) begin failures++; $display("FAIL midrst_reload_run: stream not consumed or timed out"); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL midrst_write_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (done !== 1'b1 || words_loaded !== 32'd2) begin failures++; $display("FAIL midrst_status: got done=%b words=%0d want 1 2", done, words_loaded); end
    endtask

    task automatic test_random_images;
        bit          bad;
        int          cycles;
        logic [31:0] n;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 4) == 0) n = 32'($urandom_range(MAXW + 1, MAXW + 500));
            else                           n = 32'($urandom_range(1, 8));
            words_q.delete();
            if (n <= MAXW) for (int i = 0; i < int'(n); i++) words_q.push_back($urandom());
            model_load(n, 1'b0);
            run_load(int'($urandom_range(0, 2)), bad, cycles);
            checks++; if (bad) begin failures++; $display("FAIL rand%0d_run: stream not consumed or timed out", it); end
            checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_write_count: got %0d want %0d", it, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_write[%0d]: got %h want %h", it, i, obs_q[i], exp_q[i]); end
            end
            checks++; if (done !== exp_done || error !== exp_err || cpu_hold !== !exp_done || words_loaded !== exp_words) begin
                failures++; $display("FAIL rand%0d_status: got done=%b err=%b hold=%b words=%0d want %b %b %b %0d", it, done, error, cpu_hold, words_loaded, exp_done, exp_err, !exp_done, exp_words);
            end
            checks++; if (overlap != 0) begin failures++; $display("FAIL rand%0d_ready_in_write: got %0d want 0", it, overlap); end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        bit bad;
        int cycles;
        for (int k = 0; k < 2; k++) begin
            words_q = '{32'h1, 32'h2};
            model_load(32'd2, k == 1);
            run_load(0, bad, cycles);
            checks++; if (bad) begin failures++; $display("FAIL csum%0d_run: stream not consumed or timed out", k); end
            checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL csum%0d_write_count: got %0d want 2", k, obs_q.size()); end
            checks++; if (done !== exp_done || error !== exp_err || cpu_hold !== !exp_done) begin
                failures++; $display("FAIL csum%0d_status: got done=%b err=%b hold=%b want %b %b %b", k, done, error, cpu_hold, exp_done, exp_err, !exp_done);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_oversize();
        test_empty_reload();
        test_reset_midword();
        test_random_images();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time writer for the instruction memory that the single-cycle core reads. It accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit words. It writes those words into instruction memory at consecutive word-aligned byte addresses, and holds the core in reset until the image is complete. It sits between the host link (UART RX or testbench) and the instruction memory write port.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, default 1024: instruction memory capacity in words; the image length must be ≤ this.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load. Honoured in IDLE, DONE and ERR.
- `byte_valid` in 1: host byte available.
- `byte_data` in 8: host byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: single-cycle instruction memory write strobe.
- `mem_addr` out 32: write byte address, always word-aligned.
- `mem_wdata` out 32: write word.
- `cpu_hold` out 1: 1 holds the core in reset.
- `done` out 1: image loaded, core released.
- `error` out 1: load aborted.
- `words_loaded` out 32: count of words written in the current load.

## Operation
- **Stream format:** 4-byte word count N (little-endian), then 4·N payload bytes. Each word is little-endian: first byte → [7:0], fourth → [31:24].
- **States:** IDLE, HDR, DATA, WRITE, CSUM (macro only), DONE, ERR.
- **IDLE:** `cpu_hold`=1, `byte_ready`=0. `start` → HDR; clears `words_loaded`, byte index, error.
- **HDR:** `byte_ready`=1; accepts 4 bytes into N. After the 4th byte:
  - N > MAX_WORDS → ERR, with no writes.
  - N = 0 → DONE (or CSUM when enabled).
  - otherwise → DATA.
- **DATA:** `byte_ready`=1; shifts bytes into the assembly register. The 4th accepted byte → WRITE.
- **WRITE:** one cycle.
  - `byte_ready`=0, `mem_we`=1, `mem_addr`=BASE_ADDR + 4·`words_loaded`, `mem_wdata`=assembled word.
  - `words_loaded` increments at the end of the cycle.
  - Next state: DATA if words remain; otherwise DONE (or CSUM when enabled).
- **DONE:** `cpu_hold`=0, `done`=1. `start` → HDR and re-asserts `cpu_hold` on the next cycle.
- **ERR:** `cpu_hold`=1, `error`=1. `start` → HDR.
- **Handshake:** a byte transfers only on a cycle with `byte_valid`&&`byte_ready`. `byte_valid` low stalls indefinitely with no timeout. Bytes offered while `byte_ready`=0 are not consumed.
- **Restrictions:** `start` is ignored in HDR/DATA/WRITE/CSUM. `start` coincident with an accepted byte in DONE is ignored for data; that byte is not consumed.
- **Address arithmetic:** 32-bit, wraps modulo 2^32. `mem_addr`[1:0] is always 0.

## Timing
- **Reset values:**
  - state IDLE.
  - `cpu_hold`=1.
  - `byte_ready`, `mem_we`, `done`, `error` = 0.
  - `mem_addr`, `mem_wdata`, `words_loaded` = 0.
- **Output registration:** all outputs are registered; none is combinational from inputs.
- **Per-word cost:** minimum 5 cycles (4 accepts + 1 WRITE). The full image takes 4 + 5·N cycles at full host rate.
- **First transfer:** `start` sampled high at edge k → `byte_ready`=1 from cycle k+1.
- **Release:** `done`/`cpu_hold` change on the edge that leaves the final WRITE (or CSUM). The core sees its first fetch on the following cycle.
- **Reset mid-load:** immediate return to reset values. Partially written memory is left as-is; the next load overwrites it.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:** after the last word (or N=0), CSUM accepts 4 more bytes forming a word C. The running XOR of all payload words is compared with C: equal → DONE, unequal → ERR. `cpu_hold` stays 1 on mismatch.
- **`LOADER_CHECKSUM_EN` undefined:** no CSUM state and no XOR register. The last WRITE goes straight to DONE.

## Structure
- **`loader_pkg`:** state enum `loader_state_t`, `HDR_BYTES`=4, `WORD_BYTES`=4, `CSUM_BYTES`=4.
- **Sub-module `byte_assembler`:** 2-bit byte counter plus a 32-bit little-endian shift register. Inputs: accept strobe, byte, clear. Outputs: word, `word_full`. It is reused for HDR, DATA and CSUM.

## Test plan
- **Basic load:** N=2, words 32'h00500093, 32'h00A00113, continuous valid → `mem_we` at addresses 0x0 and 0x4 with those values, `words_loaded`=2, `done`=1, `cpu_hold`=0 at cycle 14 after `start`.
- **Backpressure:** `byte_valid` toggled every other cycle, N=1, word 32'hDEADBEEF → single write of 32'hDEADBEEF at 0x0. No byte is lost or duplicated; `byte_ready`=0 during WRITE.
- **Oversize image:** N=1025 with MAX_WORDS=1024 → ERR right after the header, no `mem_we`, `error`=1, `cpu_hold`=1.
- **Empty image and reload:** N=0 → DONE with no writes. Then `start` with N=1 → `cpu_hold` returns to 1, one write at BASE_ADDR, DONE again.
- **Async reset mid-word:** `rst` low after 2 payload bytes → all outputs at reset values asynchronously. A subsequent fresh load succeeds.
- **Checksum (`LOADER_CHECKSUM_EN`):** words 32'h1, 32'h2 with C=32'h3 → DONE. The same image with C=32'h4 → ERR and `cpu_hold`=1.
